mem_cycle_sequencer: RTL and testbench
======================================

Name: mem_cycle_sequencer

Overview:
- Multi-cycle sequencer that lets the RV32I datapath run with a single shared, variable-latency memory port instead of separate instruction and data memories.
- Steps each instruction through fetch, execute, optional data access, then writeback.
- Owns the req/ack handshake to memory. Gates the PC register update and the register-file write enable.
- Latches the fetched instruction and the loaded data word for the datapath.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles mem_req may stay high without mem_ack before faulting; 0 disables the timeout.
- NOP_INSTR, 32'h00000013, value of instr_out after reset (addi x0,x0,0).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- pc_in  in  32  current PC from the PC register.
- load_en  in  1  decoded load (memtoreg) for instr_out.
- store_en  in  1  decoded store (MemW) for instr_out.
- alu_addr  in  32  ALU result; data byte address.
- store_data  in  32  regfile RD2; store data.
- mem_ack  in  1  memory completes the current request.
- mem_rdata  in  32  memory read data; valid when mem_ack=1.
- mem_req  out  1  request active.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  32  byte address.
- mem_wdata  out  32  write data.
- instr_out  out  32  latched instruction driving decode/control.
- load_data  out  32  latched load word to the MemtoReg mux.
- pc_we  out  1  one-cycle PC update enable.
- reg_we_en  out  1  one-cycle qualifier ANDed with control RegW.
- err  out  1  sticky fault flag.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset (RST=0, async): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, instr_out=NOP_INSTR, load_data=0, pc_we=0, reg_we_en=0, err=0, timeout counter=0.
- State encodings: IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, FAULT=5.
- IDLE: go to FETCH after 1 cycle.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc_in.
  - If pc_in[1:0]!=0 on entry: go to FAULT without asserting mem_req.
  - On mem_ack=1: instr_out<=mem_rdata, go to EXEC.
- EXEC: 1 cycle; the datapath settles on instr_out.
  - store_en=1: go to MEM as a write (store wins if load_en is also 1).
  - else load_en=1: go to MEM as a read.
  - else: go to WB.
  - On the EXEC->MEM edge, register mem_addr<=alu_addr, mem_wdata<=store_data and mem_we.
  - alu_addr[1:0]!=0 with a load/store: go to FAULT.
- MEM: mem_req=1 with the registered addr/we/wdata.
  - On mem_ack=1: if read, load_data<=mem_rdata. Go to WB.
- WB: pc_we=1 and reg_we_en=1 for exactly 1 cycle, then FETCH.
  - Stores and branches still pulse reg_we_en; control RegW suppresses the write.
- FAULT: terminal until reset.
  - err=1; mem_req, pc_we and reg_we_en held at 0.
  - instr_out and load_data hold their values.
- Handshake rules:
  - While mem_req=1, mem_addr, mem_we and mem_wdata do not change.
  - mem_req drops in the cycle after mem_ack is sampled high; there are no back-to-back requests without an intervening EXEC or WB cycle.
  - mem_ack while mem_req=0 is ignored and changes no state.
  - Same-cycle ack (combinational memory) is legal.
- Timeout:
  - Counter clears on every FETCH/MEM entry and increments each cycle mem_req=1 && mem_ack=0.
  - When the count reaches TIMEOUT_CYCLES: go to FAULT, err=1.
  - An ack in the same cycle the limit is reached wins (no fault).
- Latency with zero-wait memory:
  - Non-memory instruction: 3 cycles (FETCH, EXEC, WB).
  - Load/store: 4 cycles.
  - Each memory wait cycle adds 1.
- Async reset mid-transaction aborts it immediately. mem_req falls in the reset cycle; no pc_we is produced.

Test Plan:
- Reset release, memory acks in the same cycle, pc_in=0, rdata=32'h00500093 (addi) -> IDLE,FETCH,EXEC,WB; instr_out=32'h00500093; pc_we and reg_we_en high only in cycle 4; mem_req high only in cycle 2.
- Load lw, alu_addr=32'h40, mem ack after 3 wait cycles with rdata=32'hDEADBEEF -> mem_we=0, mem_addr=32'h40 stable 4 cycles; load_data=32'hDEADBEEF; pc_we pulses once, 1 cycle after ack.
- Store with store_en=1, load_en=1, store_data=32'hA5A5A5A5 -> mem_we=1, mem_wdata=32'hA5A5A5A5; load_data unchanged.
- pc_in=32'h6 at FETCH, then alu_addr=32'h41 on a load after a new reset -> FAULT in both cases; err=1; mem_req never asserted for the bad access.
- TIMEOUT_CYCLES=4, mem_ack held 0 -> err rises after 4 request cycles. Repeat with ack arriving in the 4th cycle -> no fault, normal WB.
- RST low during a MEM wait, plus a spurious mem_ack while idle -> all outputs return to reset values asynchronously; the stray ack causes no transition; fetch restarts 1 cycle after release.

Source files
------------

// File: rtl/mem_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// mem_cycle_sequencer
//
// Multi-cycle control sequencer that lets an RV32I datapath share one
// variable-latency memory port for both instruction fetch and data access.
// Every instruction is stepped through FETCH -> EXEC -> (MEM) -> WB. The block
// owns the req/ack handshake, latches the fetched instruction and the loaded
// word, and issues one-cycle PC-update and register-write qualifiers.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          asynchronous active-low reset
//   pc_in        current PC from the PC register
//   load_en      decoded load for instr_out
//   store_en     decoded store for instr_out (wins over load_en)
//   alu_addr     ALU result, data byte address
//   store_data   regfile RD2, store data
//   mem_ack      memory completes the current request
//   mem_rdata    memory read data, valid with mem_ack
//   mem_req      request active
//   mem_we       1 = write, 0 = read
//   mem_addr     byte address
//   mem_wdata    write data
//   instr_out    latched instruction for decode/control
//   load_data    latched load word for the MemtoReg mux
//   pc_we        one-cycle PC update enable
//   reg_we_en    one-cycle qualifier ANDed with control RegW
//   err          sticky fault flag
//   state_dbg    current state encoding
// -----------------------------------------------------------------------------
module mem_cycle_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] pc_in,
   input  logic        load_en,
   input  logic        store_en,
   input  logic [31:0] alu_addr,
   input  logic [31:0] store_data,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [31:0] instr_out,
   output logic [31:0] load_data,
   output logic        pc_we,
   output logic        reg_we_en,
   output logic        err,
   output logic [2:0]  state_dbg
);

   localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC  = 3'd2,
      S_MEM   = 3'd3,
      S_WB    = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   state_t      r_state;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_mem_we;
   logic [31:0] r_instr;
   logic [31:0] r_load_data;
   logic [31:0] r_tcnt;
   logic        r_pc_we;
   logic        r_reg_we_en;
   logic        r_err;

   logic        w_pc_bad;
   logic        w_addr_bad;
   logic        w_req;
   logic        w_timeout;

   assign w_pc_bad   = (pc_in[1:0] != 2'b00);
   assign w_addr_bad = (alu_addr[1:0] != 2'b00);

   // The PC register only updates on the edge that ends WB, i.e. the same edge
   // that enters FETCH, so the fetch address cannot be captured on entry. It is
   // taken straight from pc_in while in FETCH (the PC is frozen there), and a
   // misaligned PC suppresses the request before it is ever seen by memory.
   assign w_req = ((r_state == S_FETCH) && !w_pc_bad) || (r_state == S_MEM);

   // Fires on the waiting cycle that would bring the count to the limit; an
   // ack in that same cycle takes priority because it is tested first below.
   assign w_timeout = (LP_TIMEOUT != 32'd0) && w_req && !mem_ack &&
                      ((r_tcnt + 32'd1) == LP_TIMEOUT);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state     <= S_IDLE;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_instr     <= NOP_INSTR;
         r_load_data <= '0;
         r_tcnt      <= '0;
         r_pc_we     <= 1'b0;
         r_reg_we_en <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_FETCH;
               r_tcnt  <= '0;
            end
            S_FETCH: begin
               if (w_pc_bad) begin
                  r_state <= S_FAULT;
                  r_err   <= 1'b1;
               end else if (mem_ack) begin
                  r_instr <= mem_rdata;
                  r_state <= S_EXEC;
               end else if (w_timeout) begin
                  r_state <= S_FAULT;
                  r_err   <= 1'b1;
               end else begin
                  r_tcnt <= r_tcnt + 32'd1;
               end
            end
            S_EXEC: begin
               if (store_en || load_en) begin
                  if (w_addr_bad) begin
                     r_state <= S_FAULT;
                     r_err   <= 1'b1;
                  end else begin
                     r_state     <= S_MEM;
                     r_mem_addr  <= alu_addr;
                     r_mem_wdata <= store_data;
                     r_mem_we    <= store_en;   // store wins over load
                     r_tcnt      <= '0;
                  end
               end else begin
                  r_state     <= S_WB;
                  r_pc_we     <= 1'b1;
                  r_reg_we_en <= 1'b1;
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  if (!r_mem_we) begin
                     r_load_data <= mem_rdata;
                  end
                  r_mem_we    <= 1'b0;
                  r_state     <= S_WB;
                  r_pc_we     <= 1'b1;
                  r_reg_we_en <= 1'b1;
               end else if (w_timeout) begin
                  r_mem_we <= 1'b0;
                  r_state  <= S_FAULT;
                  r_err    <= 1'b1;
               end else begin
                  r_tcnt <= r_tcnt + 32'd1;
               end
            end
            S_WB: begin
               r_pc_we     <= 1'b0;
               r_reg_we_en <= 1'b0;
               r_state     <= S_FETCH;
               r_tcnt      <= '0;
            end
            S_FAULT: begin
               r_err <= 1'b1;
            end
            default: begin
               r_state     <= S_FAULT;
               r_err       <= 1'b1;
               r_pc_we     <= 1'b0;
               r_reg_we_en <= 1'b0;
               r_mem_we    <= 1'b0;
            end
         endcase
      end
   end

   assign mem_req   = w_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = (r_state == S_FETCH) ? pc_in : r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign instr_out = r_instr;
   assign load_data = r_load_data;
   assign pc_we     = r_pc_we;
   assign reg_we_en = r_reg_we_en;
   assign err       = r_err;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_cycle_sequencer
//
// Bench for mem_cycle_sequencer. The bench plays both the memory (random wait
// states, spurious acks while idle) and the datapath (PC register, decoded
// load/store). Expected behaviour per instruction comes from a transaction-level
// model: latency = 3 + mem + waits, request cycle count, addresses, the latched
// instruction and load word, and a single pc_we/reg_we_en pulse.
// -----------------------------------------------------------------------------
module tb_mem_cycle_sequencer;

   localparam int          TO  = 4;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] pc_in = '0;
   logic        load_en = 1'b0;
   logic        store_en = 1'b0;
   logic [31:0] alu_addr = '0;
   logic [31:0] store_data = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] instr_out;
   logic [31:0] load_data;
   logic        pc_we;
   logic        reg_we_en;
   logic        err;
   logic [2:0]  state_dbg;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] m_pc = '0;
   logic [31:0] m_load_data = '0;

   mem_cycle_sequencer #(
      .TIMEOUT_CYCLES (TO),
      .NOP_INSTR      (NOP)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .pc_in      (pc_in),
      .load_en    (load_en),
      .store_en   (store_en),
      .alu_addr   (alu_addr),
      .store_data (store_data),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .instr_out  (instr_out),
      .load_data  (load_data),
      .pc_we      (pc_we),
      .reg_we_en  (reg_we_en),
      .err        (err),
      .state_dbg  (state_dbg)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Asserts reset asynchronously mid-cycle, checks every output, releases it
   // and leaves the bench at the negedge of the first FETCH cycle. A stray ack
   // is driven during the IDLE cycle; it must not be latched.
   task automatic do_reset(input logic [31:0] start_pc);
      @(negedge CLK);
      #2;
      RST = 1'b0;
      load_en = 1'b0;
      store_en = 1'b0;
      #1;
      check_val("rst_state", 32'(state_dbg), 32'd0);
      check_val("rst_req", 32'(mem_req), 32'd0);
      check_val("rst_we", 32'(mem_we), 32'd0);
      check_val("rst_addr", mem_addr, 32'd0);
      check_val("rst_wdata", mem_wdata, 32'd0);
      check_val("rst_instr", instr_out, NOP);
      check_val("rst_load", load_data, 32'd0);
      check_val("rst_pc_we", 32'(pc_we), 32'd0);
      check_val("rst_reg_we", 32'(reg_we_en), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      m_pc = start_pc;
      m_load_data = '0;
      pc_in = start_pc;
      mem_ack = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      check_val("idle_state", 32'(state_dbg), 32'd0);
      check_val("idle_req", 32'(mem_req), 32'd0);
      mem_ack = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      @(negedge CLK);
      mem_ack = 1'b0;
      check_val("fetch_state", 32'(state_dbg), 32'd1);
      check_val("stray_ack_instr", instr_out, NOP);
   endtask

   task automatic run_instr(input logic [31:0] iw, input logic ld, input logic st,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd, input int fw, input int mw);
      logic        mem_op;
      logic        prev_req;
      logic [31:0] exp_ld;
      int          exp_lat;
      int          exp_req;
      int          req_cyc;
      int          pcwe_at;
      int          run_len;
      int          phase;
      mem_op  = ld | st;
      exp_lat = 3 + fw + (mem_op ? 1 + mw : 0);
      exp_req = 1 + fw + (mem_op ? 1 + mw : 0);
      exp_ld  = (ld && !st) ? rd : m_load_data;
      req_cyc = 0;
      pcwe_at = -1;
      run_len = 0;
      phase   = 0;
      prev_req = 1'b0;
      check_val("start_state", 32'(state_dbg), 32'd1);
      check_val("start_pc_we", 32'(pc_we), 32'd0);
      pc_in = m_pc;
      load_en = ld;
      store_en = st;
      alu_addr = addr;
      store_data = wd;
      for (int cyc = 0; cyc < 40 && pcwe_at < 0; cyc++) begin
         if (cyc > 0) @(negedge CLK);
         if (mem_req) begin
            if (!prev_req) begin
               phase++;
               run_len = 0;
            end
            req_cyc++;
            if (phase == 1) begin
               check_val("fetch_addr", mem_addr, m_pc);
               check_val("fetch_we", 32'(mem_we), 32'd0);
               mem_ack = (run_len == fw);
               mem_rdata = mem_ack ? iw : $urandom;
            end else begin
               check_val("data_addr", mem_addr, addr);
               check_val("data_we", 32'(mem_we), 32'(st));
               if (st) check_val("data_wdata", mem_wdata, wd);
               mem_ack = (run_len == mw);
               mem_rdata = mem_ack ? rd : $urandom;
            end
            run_len++;
         end else begin
            mem_ack = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
         end
         prev_req = mem_req;
         check_val("reg_we_vs_pc_we", 32'(reg_we_en), 32'(pc_we));
         if (pc_we) pcwe_at = cyc;
      end
      check_val("wb_latency", 32'(pcwe_at), 32'(exp_lat - 1));
      check_val("req_cycles", 32'(req_cyc), 32'(exp_req));
      check_val("instr_out", instr_out, iw);
      check_val("load_data", load_data, exp_ld);
      m_load_data = exp_ld;
      $display("instr pc=%h iw=%h ld=%0d st=%0d addr=%h fw=%0d mw=%0d lat=%0d",
               m_pc, iw, ld, st, addr, fw, mw, exp_lat);
      // PC register updates on the edge that ends WB.
      @(posedge CLK);
      #1;
      m_pc = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : m_pc + 32'd4;
      pc_in = m_pc;
      @(negedge CLK);
      mem_ack = 1'b0;
   endtask

   task automatic fault_hold(input logic [31:0] exp_instr);
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check_val("fault_state", 32'(state_dbg), 32'd5);
         check_val("fault_err", 32'(err), 32'd1);
         check_val("fault_req", 32'(mem_req), 32'd0);
         check_val("fault_pc_we", 32'(pc_we), 32'd0);
         check_val("fault_reg_we", 32'(reg_we_en), 32'd0);
         mem_ack = 1'($urandom_range(0, 1));
      end
      check_val("fault_instr_hold", instr_out, exp_instr);
      mem_ack = 1'b0;
   endtask

   initial begin
      int req_cnt;
      // Zero-wait addi, then lw with 3 wait states, then store with load_en also set.
      do_reset(32'h0);
      run_instr(32'h00500093, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);
      run_instr(32'h04002083, 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 3);
      run_instr(32'h0A102023, 1'b1, 1'b1, 32'h80, 32'hA5A5A5A5, 32'h12345678, 1, 0);

      // Randomized instruction stream, waits below the timeout limit.
      for (int n = 0; n < 40; n++) begin
         run_instr($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                   $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
      end

      // Misaligned PC: no request, fault.
      do_reset(32'h6);
      check_val("bad_pc_req", 32'(mem_req), 32'd0);
      fault_hold(NOP);

      // Misaligned load address after a good fetch.
      do_reset(32'h0);
      mem_ack = 1'b1;
      mem_rdata = 32'h04102083;
      load_en = 1'b1;
      alu_addr = 32'h41;
      @(negedge CLK);
      mem_ack = 1'b0;
      check_val("bad_addr_exec_req", 32'(mem_req), 32'd0);
      fault_hold(32'h04102083);

      // Fetch that is never acked times out after TO request cycles.
      do_reset(32'h0);
      req_cnt = 0;
      for (int i = 0; i < 12 && !err; i++) begin
         if (mem_req) req_cnt++;
         @(negedge CLK);
      end
      check_val("timeout_req_cycles", 32'(req_cnt), 32'(TO));
      check_val("timeout_err", 32'(err), 32'd1);
      check_val("timeout_state", 32'(state_dbg), 32'd5);

      // Ack arriving in the limit cycle wins, for fetch and data.
      do_reset(32'h0);
      run_instr(32'h00100113, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, TO - 1, 0);
      run_instr(32'h00012183, 1'b1, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 0, TO - 1);
      check_val("limit_ack_err", 32'(err), 32'd0);

      // Reset in the middle of a MEM wait, then restart.
      do_reset(32'h0);
      mem_ack = 1'b1;
      mem_rdata = 32'h20002083;
      load_en = 1'b1;
      alu_addr = 32'h200;
      @(negedge CLK);
      mem_ack = 1'b0;
      @(negedge CLK);
      check_val("mid_mem_req", 32'(mem_req), 32'd1);
      do_reset(32'h0);
      run_instr(32'h00300193, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
